// File: rtl/instr_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_ctrl_pkg
// Description : Shared types and constants for the instruction fetch block:
//               FSM state encoding, fetch buffer entry layout and a PC
//               legality helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_ctrl_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // A fetch is legal when word aligned and the whole word lies inside the
    // memory. Comparing against the last word address avoids computing pc+3,
    // which could wrap for PCs near 2^32.
    function automatic logic pc_legal(input logic [31:0] pc,
                                      input logic [31:0] last_pc);
        return (pc[1:0] == 2'b00) && (pc <= last_pc);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_ctrl_if
// Description : Bus bundle of the fetch controller: instruction memory read
//               port, redirect input, decode handshake and fault flag.
// Ports       : master - fetch controller side
//               slave  - memory / branch unit / decode side
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_ctrl_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_fault;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc,
        output fetch_fault
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc,
        input  fetch_fault
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Fetch buffer holding {pc, instr} entries. Flush wins over
//               push and pop. Push into a full buffer is accepted when a pop
//               happens in the same cycle. Head reads zero when empty.
// Ports       : clk, rst_n  - clock, synchronous active-low reset
//               push, din   - write request and entry
//               pop         - remove head (ignored when empty)
//               flush       - discard all entries
//               full, empty - occupancy flags
//               head        - oldest entry
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  storage [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? '0 : storage[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry data needs no reset: it is only visible through head while the
    // occupancy count says it is valid.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push_ok) storage[wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_ctrl
// Description : Instruction fetch controller. Walks the PC through byte
//               addressed instruction memory, buffers fetched words and
//               hands them to decode over valid/ready. A redirect flushes the
//               buffer and restarts fetch; an illegal PC parks the FSM in
//               FAULT with a sticky flag until the next redirect.
// Ports       : clk    - clock, rising edge
//               rst_n  - synchronous reset, active low
//               bus    - instr_fetch_ctrl_if.master (imem, redirect, decode,
//                        fetch_fault)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          MEM_BYTES  = 1024,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_ctrl_if.master  bus
);
    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - INSTR_BYTES);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         fault;
    logic         legal;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    fetch_entry_t head;
    fetch_entry_t din;

    assign legal = pc_legal(pc, LAST_PC);
    assign pop   = !empty && bus.if_ready;
    // The FIFO accepts a push into a full buffer when the head leaves in the
    // same cycle, which keeps one instruction per cycle flowing.
    assign push  = !bus.redirect_valid && (state == FETCH) && legal
                   && (!full || pop);
    assign din   = '{pc: pc, instr: bus.imem_rdata};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   (din),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= RESET_PC;
            fault <= 1'b0;
        end else if (bus.redirect_valid) begin
            state <= FETCH;
            pc    <= bus.redirect_pc;
            fault <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!legal) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end else if (push) begin
                        pc <= pc + 32'(INSTR_BYTES);
                    end
                end
                // pc is frozen here so imem_addr keeps showing the bad PC
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.fetch_fault = fault;
    assign bus.if_valid    = !empty;
    assign bus.if_instr    = head.instr;
    assign bus.if_pc       = head.pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_ctrl
// Description : Self-checking bench for instr_fetch_ctrl. Expected decode
//               transfers are queued by the stimulus; a monitor compares
//               every accepted transfer against the queue head. Timing
//               points are checked directly against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;
    import instr_fetch_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic [31:0]  mem [256];
    fetch_entry_t exp_q [$];

    instr_fetch_ctrl_if bus ();

    instr_fetch_ctrl #(
        .RESET_PC   (32'h0),
        .MEM_BYTES  (1024),
        .FIFO_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.imem_rdata = (bus.imem_addr < 32'd1024) ? mem[bus.imem_addr[9:2]]
                                                       : 32'hDEAD_DEAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic expect_xfer(input logic [31:0] pc, input logic [31:0] instr);
        exp_q.push_back('{pc: pc, instr: instr});
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        rst_n              = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        tick(1);
        bus.redirect_valid = 1'b0;
    endtask

    // Monitor: every transfer accepted by decode must match the queue head.
    always @(negedge clk) begin
        if (rst_n && bus.if_valid && bus.if_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected: got pc %h instr %h expected none",
                         bus.if_pc, bus.if_instr);
            end else begin
                fetch_entry_t e;
                e = exp_q.pop_front();
                if (bus.if_pc !== e.pc || bus.if_instr !== e.instr) begin
                    errors++;
                    $display("FAIL xfer: got pc %h instr %h expected pc %h instr %h",
                             bus.if_pc, bus.if_instr, e.pc, e.instr);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {16'hC0DE, 16'(i * 4)};
        bus.redirect_pc = 32'h0;

        // ---- 1: reset state, then stream 0, 4, 8 with ready high
        do_reset();
        rst_n = 1'b0;
        tick(1);
        chk("rst_if_valid", {31'b0, bus.if_valid}, 32'd0);
        chk("rst_fault",    {31'b0, bus.fetch_fault}, 32'd0);
        chk("rst_if_instr", bus.if_instr, 32'h0);
        chk("rst_if_pc",    bus.if_pc, 32'h0);
        chk("rst_imem_addr", bus.imem_addr, 32'h0);
        rst_n        = 1'b1;
        bus.if_ready = 1'b1;
        expect_xfer(32'h0, 32'hC0DE_0000);
        expect_xfer(32'h4, 32'hC0DE_0004);
        expect_xfer(32'h8, 32'hC0DE_0008);
        tick(1);
        chk("t1_pc0", bus.if_pc, 32'h0);
        tick(1);
        chk("t1_pc4", bus.if_pc, 32'h4);
        tick(1);
        chk("t1_pc8", bus.if_pc, 32'h8);
        chk("t1_fault", {31'b0, bus.fetch_fault}, 32'd0);
        tick(1);
        bus.if_ready = 1'b0;

        // ---- 2: back-pressure fills the buffer, release drains in order
        do_reset();
        tick(5);
        chk("t2_valid", {31'b0, bus.if_valid}, 32'd1);
        chk("t2_pc_hold", bus.if_pc, 32'h0);
        chk("t2_imem_addr", bus.imem_addr, 32'h8);
        expect_xfer(32'h0, 32'hC0DE_0000);
        expect_xfer(32'h4, 32'hC0DE_0004);
        expect_xfer(32'h8, 32'hC0DE_0008);
        bus.if_ready = 1'b1;
        tick(1);
        chk("t2_pc4", bus.if_pc, 32'h4);
        tick(1);
        chk("t2_pc8", bus.if_pc, 32'h8);
        tick(1);
        bus.if_ready = 1'b0;

        // ---- 3: redirect to 0x40 with a full buffer
        do_reset();
        tick(3);
        redirect(32'h40);
        chk("t3_flush_valid", {31'b0, bus.if_valid}, 32'd0);
        tick(1);
        chk("t3_valid", {31'b0, bus.if_valid}, 32'd1);
        chk("t3_pc", bus.if_pc, 32'h40);
        chk("t3_instr", bus.if_instr, 32'hC0DE_0040);
        expect_xfer(32'h40, 32'hC0DE_0040);
        bus.if_ready = 1'b1;
        tick(1);
        bus.if_ready = 1'b0;

        // ---- 4: misaligned redirect faults; redirect to 0x10 recovers
        do_reset();
        redirect(32'h42);
        chk("t4_valid0", {31'b0, bus.if_valid}, 32'd0);
        tick(1);
        chk("t4_fault", {31'b0, bus.fetch_fault}, 32'd1);
        chk("t4_valid1", {31'b0, bus.if_valid}, 32'd0);
        tick(1);
        chk("t4_fault_sticky", {31'b0, bus.fetch_fault}, 32'd1);
        chk("t4_imem_addr", bus.imem_addr, 32'h42);
        redirect(32'h10);
        chk("t4_fault_clr", {31'b0, bus.fetch_fault}, 32'd0);
        tick(1);
        chk("t4_pc", bus.if_pc, 32'h10);
        expect_xfer(32'h10, 32'hC0DE_0010);
        bus.if_ready = 1'b1;
        tick(1);
        bus.if_ready = 1'b0;

        // ---- 5: last legal word, then fault on 0x400
        do_reset();
        redirect(32'h3FC);
        expect_xfer(32'h3FC, 32'hC0DE_03FC);
        bus.if_ready = 1'b1;
        tick(1);
        chk("t5_pc", bus.if_pc, 32'h3FC);
        tick(1);
        chk("t5_fault", {31'b0, bus.fetch_fault}, 32'd1);
        chk("t5_valid", {31'b0, bus.if_valid}, 32'd0);
        chk("t5_imem_addr", bus.imem_addr, 32'h400);
        tick(2);
        chk("t5_valid_late", {31'b0, bus.if_valid}, 32'd0);
        bus.if_ready = 1'b0;

        // ---- 6: reset mid-stream with a full buffer
        do_reset();
        tick(3);
        rst_n = 1'b0;
        tick(1);
        chk("t6_valid", {31'b0, bus.if_valid}, 32'd0);
        chk("t6_imem_addr", bus.imem_addr, 32'h0);
        rst_n = 1'b1;
        tick(1);
        chk("t6_restart_pc", bus.if_pc, 32'h0);
        expect_xfer(32'h0, 32'hC0DE_0000);
        bus.if_ready = 1'b1;
        tick(1);
        bus.if_ready = 1'b0;
        tick(2);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
